// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: formats stores, drives a req/ack
// data bus, stalls the pipeline while waiting and returns extended load data.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_have_inst,
  input  logic [31:0] MEM_inst,
  input  logic        MEM_ram_we,
  input  logic        MEM_ram_re,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_rD2,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wmask,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        access_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic            r_is_load;

  logic [2:0] w_f3;
  logic [1:0] w_off;
  logic       w_store;
  logic       w_access;
  logic       w_legal;
  logic       w_misalign;
  logic       w_start;
  logic       w_timeout;
  logic       w_unused_ok;

  assign w_f3        = MEM_inst[14:12];
  assign w_off       = MEM_alu_result[1:0];
  assign w_store     = MEM_ram_we;
  assign w_access    = MEM_have_inst & (MEM_ram_we | MEM_ram_re);
  assign w_unused_ok = ^{MEM_inst[31:15], MEM_inst[11:0]};
  assign w_timeout   = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Store lane formatting: returns {wmask, wdata}
  function automatic logic [35:0] fmt_store(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
    case (f3)
      3'b000:  fmt_store = {4'b0001 << off, {4{d[7:0]}}};
      3'b001:  fmt_store = {4'b0011 << off, {2{d[15:0]}}};
      default: fmt_store = {4'b1111, d};
    endcase
  endfunction

  // Load lane extraction with sign/zero extension
  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] w;
    w = rd >> {off, 3'b000};
    case (f3)
      3'b000:  ext_load = {{24{w[7]}}, w[7:0]};
      3'b100:  ext_load = {24'd0, w[7:0]};
      3'b001:  ext_load = {{16{w[15]}}, w[15:0]};
      3'b101:  ext_load = {16'd0, w[15:0]};
      default: ext_load = w;
    endcase
  endfunction

  // Width-code legality and alignment
  always_comb begin
    w_legal = 1'b0;
    case (w_f3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~w_store;
      default:                w_legal = 1'b0;
    endcase
    w_misalign = ~w_legal
               | ((w_f3[1:0] == 2'b01) & w_off[0])
               | ((w_f3 == 3'b010) & (w_off != 2'b00));
    w_start = w_access & ~w_misalign;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, stall and access-error decode
  always_comb begin
    w_next     = r_state;
    mem_stall  = 1'b0;
    access_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          mem_stall = 1'b1;
          w_next    = S_WAIT;
        end else begin
          access_err = w_access & w_misalign;
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (dbus_ack | w_timeout) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus request, timeout counter and load-result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_wmask <= 4'd0;
      dbus_wdata <= 32'd0;
      ld_data    <= 32'd0;
      ld_valid   <= 1'b0;
      bus_err    <= 1'b0;
      r_cnt      <= '0;
      r_f3       <= 3'd0;
      r_off      <= 2'd0;
      r_is_load  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
          if (w_start) begin
            dbus_req  <= 1'b1;
            dbus_we   <= w_store;
            dbus_addr <= {MEM_alu_result[31:2], 2'b00};
            if (w_store) begin
              {dbus_wmask, dbus_wdata} <= fmt_store(w_f3, w_off, MEM_rD2);
            end else begin
              dbus_wmask <= 4'd0;
              dbus_wdata <= 32'd0;
            end
            r_cnt     <= '0;
            r_f3      <= w_f3;
            r_off     <= w_off;
            r_is_load <= ~w_store;
          end
        end
        S_WAIT: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            ld_data  <= r_is_load ? ext_load(r_f3, r_off, dbus_rdata) : 32'd0;
            ld_valid <= r_is_load;
          end else if (w_timeout) begin
            dbus_req <= 1'b0;
            bus_err  <= 1'b1;
            ld_data  <= 32'd0;
            ld_valid <= r_is_load;
          end else begin
            r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
        end
        default: begin
          dbus_req <= 1'b0;
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus requests and completions
// are queued by the stimulus and consumed by an independent negedge monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MEM_have_inst = 1'b0;
  logic [31:0] MEM_inst = 32'd0;
  logic        MEM_ram_we = 1'b0;
  logic        MEM_ram_re = 1'b0;
  logic [31:0] MEM_alu_result = 32'd0;
  logic [31:0] MEM_rD2 = 32'd0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wmask;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = 32'd0;
  logic        mem_stall, ld_valid, access_err, bus_err;
  logic [31:0] ld_data;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .MEM_have_inst(MEM_have_inst), .MEM_inst(MEM_inst),
    .MEM_ram_we(MEM_ram_we), .MEM_ram_re(MEM_ram_re), .MEM_alu_result(MEM_alu_result),
    .MEM_rD2(MEM_rD2), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wmask(dbus_wmask), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .ld_data(ld_data),
    .ld_valid(ld_valid), .access_err(access_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic we; logic [3:0] mask; logic [31:0] wdata;} bus_t;
  typedef struct {logic ldv; logic [31:0] ldd; logic berr; int stall;} done_t;

  bus_t  q_bus[$];
  done_t q_done[$];
  int    checks = 0;
  int    errors = 0;
  int    aerr_seen = 0;
  logic  mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares bus requests and completions against the queues
  initial begin
    bus_t  b;
    done_t d;
    logic  prev_req;
    int    stall_cnt;
    prev_req  = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_req  = 1'b0;
        stall_cnt = 0;
      end else begin
        if (mem_stall) stall_cnt++;
        if (dbus_req && !prev_req) begin
          if (q_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %h expected no request", dbus_addr);
          end else begin
            b = q_bus.pop_front();
            chk("bus_addr", dbus_addr, b.addr);
            chk("bus_we", {31'd0, dbus_we}, {31'd0, b.we});
            chk("bus_wmask", {28'd0, dbus_wmask}, {28'd0, b.mask});
            if (b.we) chk("bus_wdata", dbus_wdata, b.wdata);
          end
        end
        if (prev_req && !dbus_req) begin
          if (q_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got completion expected none");
          end else begin
            d = q_done.pop_front();
            chk("ld_valid", {31'd0, ld_valid}, {31'd0, d.ldv});
            chk("ld_data", ld_data, d.ldd);
            chk("bus_err", {31'd0, bus_err}, {31'd0, d.berr});
            chk("stall_cycles", 32'(stall_cnt), 32'(d.stall));
          end
          stall_cnt = 0;
        end else if (ld_valid || bus_err) begin
          checks++; errors++;
          $display("FAIL stray_pulse: got ld_valid=%b bus_err=%b expected 0", ld_valid, bus_err);
        end
        if (access_err) begin
          aerr_seen++;
          chk("aerr_quiet_bus", {30'd0, dbus_req, mem_stall}, 32'd0);
        end
        prev_req = dbus_req;
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    MEM_have_inst  = 1'b1;
    MEM_ram_we     = we;
    MEM_ram_re     = re;
    MEM_inst       = {17'd0, f3, 12'd0};
    MEM_alu_result = addr;
    MEM_rD2        = wd;
  endtask

  // One access: ack_at = WAIT cycle carrying the ack, 0 = never acknowledged
  task automatic access(input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ack_at,
                        input logic [3:0] e_mask, input logic [31:0] e_wdata,
                        input logic e_ldv, input logic [31:0] e_ldd, input logic e_berr);
    bus_t  b;
    done_t d;
    int    n;
    b.addr = {addr[31:2], 2'b00}; b.we = we; b.mask = e_mask; b.wdata = e_wdata;
    d.ldv = e_ldv; d.ldd = e_ldd; d.berr = e_berr;
    d.stall = (ack_at > 0) ? ack_at + 1 : 5;
    q_bus.push_back(b);
    q_done.push_back(d);
    drive(we, re, f3, addr, wd);
    @(posedge clk); #1;
    if (ack_at > 0) begin
      repeat (ack_at - 1) begin @(posedge clk); #1; end
      dbus_ack   = 1'b1;
      dbus_rdata = rdata;
      @(posedge clk); #1;
      dbus_ack   = 1'b0;
    end else begin
      n = 0;
      while (dbus_req && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL timeout_wait: got dbus_req still high expected drop");
      end
    end
    @(posedge clk); #1;
    MEM_have_inst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bad_access(input logic we, input logic re, input logic [2:0] f3,
                            input logic [31:0] addr);
    drive(we, re, f3, addr, 32'h5555_5555);
    #1;
    chk("access_err_pulse", {31'd0, access_err}, 32'd1);
    chk("access_err_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    MEM_have_inst = 1'b0;
    chk("access_err_noreq", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_wmask", {28'd0, dbus_wmask}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // sw, lb, lbu, sh, sb (we=re=1 counts as store), lh, lhu
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    access(1'b0, 1'b1, 3'b000, 32'h203, 32'd0, 32'h80FF_0000, 4, 4'b0000, 32'd0, 1'b1, 32'hFFFF_FF80, 1'b0);
    chk("ld_data_hold", ld_data, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 3'b100, 32'h203, 32'd0, 32'h80FF_0000, 4, 4'b0000, 32'd0, 1'b1, 32'h0000_0080, 1'b0);
    access(1'b1, 1'b0, 3'b001, 32'h302, 32'h1234_ABCD, 32'd0, 2, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'd0, 1'b0);
    access(1'b1, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'hFFFF_FFFF, 1, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'd0, 1'b0);
    access(1'b0, 1'b1, 3'b001, 32'h202, 32'd0, 32'h8001_1234, 3, 4'b0000, 32'd0, 1'b1, 32'hFFFF_8001, 1'b0);
    access(1'b0, 1'b1, 3'b101, 32'h202, 32'd0, 32'h8001_1234, 1, 4'b0000, 32'd0, 1'b1, 32'h0000_8001, 1'b0);

    // misaligned and illegal-width accesses
    bad_access(1'b0, 1'b1, 3'b010, 32'h105);
    bad_access(1'b0, 1'b1, 3'b011, 32'h100);
    bad_access(1'b1, 1'b0, 3'b100, 32'h100);
    bad_access(1'b0, 1'b1, 3'b001, 32'h201);

    // timeout, then a late ack in IDLE
    access(1'b0, 1'b1, 3'b010, 32'h400, 32'd0, 32'd0, 0, 4'b0000, 32'd0, 1'b1, 32'd0, 1'b1);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    chk("late_ack_req", {31'd0, dbus_req}, 32'd0);
    chk("late_ack_ld_data", ld_data, 32'd0);
    chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;

    // load leaves a nonzero ld_data, then reset during WAIT
    access(1'b0, 1'b1, 3'b101, 32'h202, 32'd0, 32'h8001_1234, 1, 4'b0000, 32'd0, 1'b1, 32'h0000_8001, 1'b0);
    mon_en = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h500, 32'd0);
    @(posedge clk); #1;
    chk("wait_req", {31'd0, dbus_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    MEM_have_inst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_req", {31'd0, dbus_req}, 32'd0);
    chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
    chk("midrst_ld_data", ld_data, 32'd0);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    chk("postrst_ack_req", {31'd0, dbus_req}, 32'd0);
    chk("postrst_ack_ldv", {31'd0, ld_valid}, 32'd0);
    chk("postrst_ack_ld_data", ld_data, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 3'b010, 32'h600, 32'd0, 32'h1122_3344, 1, 4'b0000, 32'd0, 1'b1, 32'h1122_3344, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("access_err_count", 32'(aerr_seen), 32'd4);
    chk("bus_queue_empty", 32'(q_bus.size()), 32'd0);
    chk("done_queue_empty", 32'(q_done.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
